uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx serializer among NUM_REQ byte-stream requesters.
//  Arbitration is round-robin. Each grant is locked for a whole message, up to and including the req_last beat.
//  The upstream data/valid/ready of each requester is mapped onto the single data/valid/ready port of uart_tx.
//  Bytes of a message are never interleaved with another requester's bytes on the line.
// PARAMETERS
//  NUM_REQ     4   number of requesters, >=2
//  DATA_WIDTH  8   byte width; must equal uart_tx DATA_WIDTH
//  MAX_BURST   16  max beats per grant, >=1; grant is force-released after this many beats even without req_last
// PORTS
//  clk        in   1                   single clock
//  rstn       in   1                   reset, asynchronous, active-low
//  req_data   in   NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_valid  in   NUM_REQ             requester i has a beat
//  req_last   in   NUM_REQ             beat is last of message; qualified by req_valid
//  req_ready  out  NUM_REQ             requester i beat accepted when req_valid[i] & req_ready[i]
//  tx_data    out  DATA_WIDTH          to uart_tx data
//  tx_valid   out  1                   to uart_tx valid
//  tx_ready   in   1                   from uart_tx ready
//  grant      out  NUM_REQ             one-hot current owner; all zero when idle
//  busy       out  1                   high while state is LOCK
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset values:
//   tx_valid=0, tx_data=0, grant=0, busy=0, req_ready=0 (combinational from state);
//   rr pointer=0, beat count=0, state=IDLE.
//  Holding register: tx_data/tx_valid are registered, never combinational from tx_ready.
//   tx_data is stable while tx_valid=1.
//   Handoff to uart_tx occurs on any edge with tx_valid & tx_ready; tx_valid clears on that edge.
//  FSM states:
//   IDLE:
//    - If no req_valid: stay.
//    - Else pick the first i with req_valid[i], searching ascending from ptr with wrap-around.
//    - Set grant=onehot(i), clear beat count, go to LOCK.
//    - req_ready=0 in IDLE.
//   LOCK:
//    - req_ready[g] = !tx_valid & !done. All other req_ready bits are 0.
//    - On accept: tx_data<=req_data[g], tx_valid<=1, beat count+1.
//    - done<=1 if req_last[g] or the new beat count == MAX_BURST.
//    - When done=1 and the holding beat is handed off (tx_valid & tx_ready):
//      go to IDLE, grant<=0, ptr<=(g+1) mod NUM_REQ, done<=0.
//  Latency:
//   - req_valid rises in IDLE at cycle 0 -> grant/busy at cycle 1 -> req_ready at cycle 1.
//   - Beat accepted at the end of cycle 1 -> tx_valid at cycle 2.
//   - After the final handoff there is exactly one IDLE cycle before the next grant.
//  Throughput: at most one beat in flight. The next beat is accepted the cycle after handoff, far faster than one UART frame.
//  Boundaries:
//   - Requester drops req_valid mid-message: grant is held and waits with no timeout.
//   - req_last together with the MAX_BURST-th beat: single release, no extra beat.
//   - Simultaneous requests: lowest index at or after ptr wins. ptr wraps NUM_REQ-1 -> 0.
//   - Valid on a non-granted requester during LOCK: ignored, req_ready stays 0, no data lost.
//   - Reset asserted mid-operation: all outputs immediately take reset values. A partial frame is left to uart_tx's own reset.
//  Width rules:
//   - ptr and grant index are $clog2(NUM_REQ) bits.
//   - Beat count is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST.
// TESTING
//  1. Req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), uart_tx model accepts each after 10 cycles
//     -> tx_data sequence 41,42,43, grant=0001 throughout, returns to 0000 one cycle after third handoff.
//  2. req_valid=1111 at reset release, each sends 1 byte (last=1)
//     -> grant order 0,1,2,3,0; ptr wraps; no interleaving.
//  3. Req2 streams 20 bytes with no last, MAX_BURST=16, req1 pending
//     -> release after 16th handoff, grant=0010 next, req2 resumes after req1.
//  4. Req1 granted, drops valid 50 cycles mid-message while req3 valid
//     -> grant stays 0010, req_ready[3]=0 throughout, tx_valid=0 until req1 resumes.
//  5. rstn pulsed low asynchronously while tx_valid=1 in LOCK
//     -> tx_valid, grant, busy, req_ready go 0 without a clock edge; first grant after reset goes to lowest valid index.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer among NUM_REQ byte streams.
// A grant is held for a whole message (through req_last) or MAX_BURST beats, whichever comes first.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         gidx_q, gidx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

    logic                  pick_found;
    logic [PW-1:0]         pick_idx;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic [CW-1:0]         cnt_inc;
    logic                  accept;
    logic                  handoff;

    // Rotating search: first valid requester at or after ptr, wrapping past NUM_REQ-1.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_found && req_valid[PW'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == PW'(i)) begin
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        grant     = '0;
        if (state_q == LOCK) begin
            grant[gidx_q] = 1'b1;
            if (!tx_valid_q && !done_q) req_ready[gidx_q] = 1'b1;
        end
    end

    assign accept   = (state_q == LOCK) && sel_valid && !tx_valid_q && !done_q;
    assign handoff  = tx_valid_q && tx_ready;
    assign cnt_inc  = cnt_q + 1'b1;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q == LOCK);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (handoff) tx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (accept) begin
                    tx_data_d  = sel_data;
                    tx_valid_d = 1'b1;
                    cnt_d      = cnt_inc;
                    done_d     = sel_last || (cnt_inc == CW'(MAX_BURST));
                end
                // Release only once the final beat has actually left the holding register.
                if (done_q && handoff) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    ptr_d   = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: expected {grant,byte} pairs are queued as messages are loaded and popped at each uart_tx handoff.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR-1:0]  req_last = '0;
    logic [NR-1:0]  req_ready;
    logic [DW-1:0]  tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b0;
    logic [NR-1:0]  grant;
    logic           busy;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(16)) dut (
        .clk(clk), .rstn(rstn), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [8:0]  rq [NR][$];   // per-requester pending beats {last, data}
    logic [11:0] exq[$];       // expected {grant, tx_data} at each handoff
    int errs = 0, checks = 0;
    int dly = 1, wcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        logic [8:0] b;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                b = rq[i][0];
                req_valid[i] = 1'b1;
                req_last[i]  = b[8];
                req_data[i*DW +: DW] = b[7:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic last);
        rq[r].push_back({last, d});
        exq.push_back({4'(1 << r), d});
    endtask

    // One clock: sample handshakes mid-cycle, then update requesters and the uart_tx model after the edge.
    task automatic tick();
        logic [NR-1:0] acc;
        logic hand;
        logic [11:0] e;
        @(negedge clk);
        acc  = req_valid & req_ready;
        hand = tx_valid & tx_ready;
        if (hand) begin
            if (exq.size() == 0) chk("sb_nonempty", 32'(exq.size() > 0), 1);
            else begin
                e = exq.pop_front();
                chk("tx_beat", {20'd0, grant, tx_data}, {20'd0, e});
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++)
            if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (hand) begin
            tx_ready = 1'b0;
            wcnt = 0;
        end else if (tx_valid && !tx_ready) begin
            wcnt++;
            if (wcnt >= dly) tx_ready = 1'b1;
        end
        drive();
    endtask

    task automatic wait_until(input string tag, input int n, input int limit);
        int c;
        c = 0;
        while (exq.size() > n && c < limit) begin
            tick();
            c++;
        end
        if (c >= limit) chk({"timeout_", tag}, exq.size(), n);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NR; i++) rq[i].delete();
        exq.delete();
        tx_ready = 1'b0;
        wcnt = 0;
    endtask

    // Reset with whatever has been loaded presented during reset, released mid-cycle.
    task automatic reset_dut();
        rstn = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        drive();
    endtask

    initial begin
        // Reset state
        clear_all();
        reset_dut();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);

        // 1: req0 three-byte message, slow uart_tx
        dly = 10;
        load(0, 8'h41, 0); load(0, 8'h42, 0); load(0, 8'h43, 1);
        drive();
        chk("t1_c0_grant", grant, 0);
        tick();
        chk("t1_c1_grant", grant, 4'b0001);
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_ready", req_ready, 4'b0001);
        chk("t1_c1_txv", tx_valid, 0);
        tick();
        chk("t1_c2_txv", tx_valid, 1);
        chk("t1_c2_data", tx_data, 8'h41);
        chk("t1_c2_ready", req_ready, 0);
        wait_until("t1", 0, 200);
        chk("t1_release_grant", grant, 0);
        chk("t1_release_busy", busy, 0);
        tick();
        chk("t1_idle_grant", grant, 0);

        // 2: all four valid at reset release, req0 comes back for a second message
        clear_all();
        dly = 2;
        load(0, 8'h10, 1); load(1, 8'h11, 1); load(2, 8'h12, 1); load(3, 8'h13, 1);
        load(0, 8'h14, 1);
        reset_dut();
        wait_until("t2", 0, 200);

        // 3: req2 streams 20 bytes, forced release after 16, req1 served in between
        clear_all();
        dly = 1;
        reset_dut();
        for (int k = 0; k < 16; k++) load(2, 8'(8'h20 + k), 0);
        drive();
        repeat (3) tick();
        load(1, 8'hA1, 1);
        for (int k = 16; k < 20; k++) load(2, 8'(8'h20 + k), k == 19);
        drive();
        wait_until("t3", 0, 400);

        // 3b: req_last coincides with the 16th beat -> single release
        clear_all();
        for (int k = 0; k < 16; k++) load(0, 8'(8'h80 + k), k == 15);
        load(1, 8'hB1, 1);
        reset_dut();
        wait_until("t3b", 0, 400);

        // 4: req1 stalls mid-message while req3 waits
        clear_all();
        dly = 2;
        reset_dut();
        load(1, 8'h31, 0); load(1, 8'h32, 0);
        drive();
        repeat (2) tick();
        rq[3].push_back({1'b1, 8'h73});
        drive();
        exq.push_back({4'b0010, 8'h33});
        exq.push_back({4'b0010, 8'h34});
        exq.push_back({4'b1000, 8'h73});
        wait_until("t4a", 3, 100);
        for (int c = 0; c < 50; c++) begin
            tick();
            chk("t4_grant_held", grant, 4'b0010);
            chk("t4_ready3", req_ready[3], 0);
            chk("t4_txv", tx_valid, 0);
        end
        rq[1].push_back({1'b0, 8'h33});
        rq[1].push_back({1'b1, 8'h34});
        drive();
        wait_until("t4b", 0, 200);

        // 5: asynchronous reset while a beat sits in the holding register
        clear_all();
        dly = 1000;
        reset_dut();
        rq[0].push_back({1'b1, 8'h50});
        drive();
        for (int c = 0; c < 10 && !tx_valid; c++) tick();
        chk("t5_txv_before", tx_valid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t5_async_txv", tx_valid, 0);
        chk("t5_async_grant", grant, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_ready", req_ready, 0);
        clear_all();
        dly = 3;
        load(2, 8'h62, 1); load(3, 8'h63, 1);
        drive();
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        chk("t5_first_grant", grant, 4'b0100);
        wait_until("t5", 0, 200);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
